// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command and
// response bytes, and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_ACK       = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] CMD_LED    = 8'hED;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    // PS/2 frames use odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side request/status bundle of the PS/2 transmitter.
interface ps2_host_tx_if;
    logic       Tx_Start;
    logic [7:0] Tx_Data;
    logic       Tx_Busy;
    logic       Tx_Done;
    logic       Tx_Err;

    modport master (output Tx_Start, Tx_Data, input Tx_Busy, Tx_Done, Tx_Err);
    modport slave  (input Tx_Start, Tx_Data, output Tx_Busy, Tx_Done, Tx_Err);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 pin plus a falling-edge strobe.
// Also used by the receiver path on the same clock.
module ps2_sync_edge (
    input  logic Clk_T,
    input  logic Reset_T,
    input  logic pin,
    output logic level,
    output logic fall
);
    logic meta, sync, sync_d;

    // Reset to the idle-high bus level so release of reset cannot fake an edge.
    always_ff @(posedge Clk_T or negedge Reset_T) begin
        if (!Reset_T) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            meta   <= pin;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync;
    assign fall  = sync_d & ~sync;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device
// clock falls, line-ack check and overall timeout.
//   state        | meaning
//   ST_IDLE      | lines released, waiting for Tx_Start
//   ST_INHIBIT   | clock held low; data pulled low in the last cycle (start bit)
//   ST_SHIFT     | clock released; next frame bit driven on each device fall
//   ST_ACK       | stop bit out; next fall samples the device ack
//   ST_WAIT_IDLE | waiting for both lines to return high
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          Clk_T,
    input  logic          Reset_T,
    ps2_host_tx_if.slave  host,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    ps2_tx_state_t    state;
    logic [TMR_W-1:0] tmr;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;
    logic             clk_oe, data_oe, busy, done, err;
    logic             clk_lvl, clk_fall;
    logic             data_meta, data_lvl;

    ps2_sync_edge u_clk_sync (
        .Clk_T   (Clk_T),
        .Reset_T (Reset_T),
        .pin     (ps2_clk_in),
        .level   (clk_lvl),
        .fall    (clk_fall)
    );

    always_ff @(posedge Clk_T or negedge Reset_T) begin
        if (!Reset_T) begin
            data_meta <= 1'b1;
            data_lvl  <= 1'b1;
        end else begin
            data_meta <= ps2_data_in;
            data_lvl  <= data_meta;
        end
    end

    always_ff @(posedge Clk_T or negedge Reset_T) begin
        if (!Reset_T) begin
            state   <= ST_IDLE;
            tmr     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host.Tx_Start) begin
                        shreg   <= {1'b1, odd_parity(host.Tx_Data), host.Tx_Data};
                        tmr     <= TMR_W'(INHIBIT_CYCLES - 1);
                        clk_oe  <= 1'b1;
                        data_oe <= (INHIBIT_CYCLES == 1);
                        busy    <= 1'b1;
                        state   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (tmr == '0) begin
                        clk_oe  <= 1'b0;
                        data_oe <= 1'b1;
                        tmr     <= TMR_W'(TIMEOUT_CYCLES - 1);
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                        if (tmr == TMR_W'(1)) data_oe <= 1'b1;
                    end
                end
                default: begin
                    // Timeout wins over a device fall landing in the same cycle.
                    if (tmr == '0) begin
                        clk_oe  <= 1'b0;
                        data_oe <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                        case (state)
                            ST_SHIFT: begin
                                if (clk_fall) begin
                                    data_oe <= ~shreg[0];
                                    shreg   <= {1'b0, shreg[9:1]};
                                    bit_cnt <= bit_cnt + 4'd1;
                                    if (bit_cnt == 4'd9) state <= ST_ACK;
                                end
                            end
                            ST_ACK: begin
                                if (clk_fall) begin
                                    if (data_lvl) begin
                                        busy  <= 1'b0;
                                        err   <= 1'b1;
                                        state <= ST_IDLE;
                                    end else begin
                                        state <= ST_WAIT_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (clk_lvl && data_lvl) begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end
                            end
                            default: begin
                                clk_oe  <= 1'b0;
                                data_oe <= 1'b0;
                                busy    <= 1'b0;
                                state   <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ps2_clk_oe   = clk_oe;
    assign ps2_data_oe  = data_oe;
    assign host.Tx_Busy = busy;
    assign host.Tx_Done = done;
    assign host.Tx_Err  = err;
endmodule
